// File: rtl/alu_r_pkg.sv
// Shared constants, FSM encoding and the legality check for the R-type issue block.
package alu_r_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WB
  } state_e;

  // The alternate func7 only exists for SUB and SRA.
  function automatic logic is_legal(input logic [31:0] ins);
    logic alt_ok;
    alt_ok = 1'b0;
    case (ins[14:12])
      F3_ADD_SUB, F3_SRL_SRA: alt_ok = 1'b1;
      F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_OR, F3_AND: alt_ok = 1'b0;
    endcase
    return (ins[6:0] == OPC_OP) &&
           ((ins[31:25] == F7_BASE) || ((ins[31:25] == F7_ALT) && alt_ok));
  endfunction

endpackage

// File: rtl/alu_r_regfile.sv
// 32x32 register file: two operand read ports, a debug read port, one write port.
// x0 reads as zero and ignores writes; the whole array clears on reset.
module alu_r_regfile
  import alu_r_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  output logic [XLEN-1:0]   rdata1_o,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [XLEN-1:0]   rdata2_o,
  input  logic [REG_AW-1:0] raddr3_i,
  output logic [XLEN-1:0]   rdata3_o
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  // NOTE: this array is deliberately reset (architectural state must clear), so it
  // maps to flops rather than RAM; sequential state always uses non-blocking <=.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
  assign rdata3_o = (raddr3_i == '0) ? '0 : regs_q[raddr3_i];

endmodule

// File: rtl/alu_r_issue.sv
// Issue/writeback front end for the R-type ALU: accept, decode, hold operands, write back.
// Optional ALU_R_ISSUE_PERF_EN adds retired/illegal instruction counters.
module alu_r_issue
  import alu_r_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic        alu_req,
  output logic [2:0]  alu_func3,
  output logic [6:0]  alu_func7,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata
`ifdef ALU_R_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_illegal
`endif
);

  localparam logic [2:0] LAT_LAST = 3'(ALU_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] instr_q;
  logic [2:0]  f3_q;
  logic [6:0]  f7_q;
  logic [4:0]  rd_q;
  logic [31:0] op1_q, op2_q, res_q;
  logic [31:0] rf_rs1, rf_rs2;
  logic        dec_legal;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign dec_legal = is_legal(instr_q);

  // Debug writes only land in IDLE, so they can never collide with writeback.
  assign rf_we    = (state_q == ST_WB) || ((state_q == ST_IDLE) && dbg_we);
  assign rf_waddr = (state_q == ST_WB) ? rd_q  : dbg_addr;
  assign rf_wdata = (state_q == ST_WB) ? res_q : dbg_wdata;

  alu_r_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .raddr1_i (instr_q[19:15]),
    .rdata1_o (rf_rs1),
    .raddr2_i (instr_q[24:20]),
    .rdata2_o (rf_rs2),
    .raddr3_i (dbg_addr),
    .rdata3_o (dbg_rdata)
  );

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
      ST_DECODE: begin
        state_d = dec_legal ? ST_EXEC : ST_IDLE;
        cnt_d   = '0;
      end
      ST_EXEC: begin
        if (cnt_q == LAT_LAST) state_d = ST_WB;
        else                   cnt_d   = cnt_q + 3'd1;
      end
      ST_WB:     state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      f3_q    <= '0;
      f7_q    <= '0;
      rd_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == ST_IDLE) && instr_valid) instr_q <= instr;
      if ((state_q == ST_DECODE) && dec_legal) begin
        op1_q <= rf_rs1;
        op2_q <= rf_rs2;
        f3_q  <= instr_q[14:12];
        f7_q  <= instr_q[31:25];
        rd_q  <= instr_q[11:7];
      end
      if ((state_q == ST_EXEC) && (cnt_q == LAT_LAST)) res_q <= alu_result;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign alu_req     = (state_q == ST_EXEC);
  assign wb_valid    = (state_q == ST_WB);
  assign illegal     = (state_q == ST_DECODE) && !dec_legal;
  assign alu_func3   = f3_q;
  assign alu_func7   = f7_q;
  assign alu_rs1     = op1_q;
  assign alu_rs2     = op2_q;
  assign wb_rd       = rd_q;
  assign wb_data     = res_q;

`ifdef ALU_R_ISSUE_PERF_EN
  logic [31:0] retired_q, illegal_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q     <= '0;
      illegal_cnt_q <= '0;
    end else begin
      if (wb_valid) retired_q     <= retired_q + 32'd1;
      if (illegal)  illegal_cnt_q <= illegal_cnt_q + 32'd1;
    end
  end

  assign perf_retired = retired_q;
  assign perf_illegal = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_r_issue.sv
// Self-checking bench for alu_r_issue: directed cases, randomized instructions against a
// register-file reference model, reset abort, and back-to-back throughput at ALU_LAT=3.
module tb_alu_r_issue;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, instr_valid3;
  logic [31:0] instr;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] alu_result;

  logic        instr_ready, alu_req, wb_valid, illegal;
  logic [2:0]  alu_func3;
  logic [6:0]  alu_func7;
  logic [31:0] alu_rs1, alu_rs2, wb_data, dbg_rdata;
  logic [4:0]  wb_rd;

  logic        instr_ready3, alu_req3, wb_valid3, illegal3;
  logic [2:0]  alu_func3_3;
  logic [6:0]  alu_func7_3;
  logic [31:0] alu_rs1_3, alu_rs2_3, wb_data3, dbg_rdata3;
  logic [4:0]  wb_rd3;

`ifdef ALU_R_ISSUE_PERF_EN
  logic [31:0] perf_retired, perf_illegal, perf_retired3, perf_illegal3;
  int unsigned exp_ret = 0;
  int unsigned exp_ill = 0;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] ref_rf [32];

  always #5 clk = ~clk;

  alu_r_issue #(.ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_req(alu_req), .alu_func3(alu_func3), .alu_func7(alu_func7),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_result(alu_result), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
`ifdef ALU_R_ISSUE_PERF_EN
    , .perf_retired(perf_retired), .perf_illegal(perf_illegal)
`endif
  );

  alu_r_issue #(.ALU_LAT(LAT3)) dut3 (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid3), .instr_ready(instr_ready3),
    .instr(instr), .alu_req(alu_req3), .alu_func3(alu_func3_3), .alu_func7(alu_func7_3),
    .alu_rs1(alu_rs1_3), .alu_rs2(alu_rs2_3), .alu_result(alu_result), .wb_valid(wb_valid3),
    .wb_rd(wb_rd3), .wb_data(wb_data3), .illegal(illegal3), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata3)
`ifdef ALU_R_ISSUE_PERF_EN
    , .perf_retired(perf_retired3), .perf_illegal(perf_illegal3)
`endif
  );

  // Architectural meaning of each R-type operation.
  function automatic logic [31:0] alu_fn(input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return f7[5] ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // The external combinational ALU, driven by the primary DUT's operand outputs.
  always_comb alu_result = alu_fn(alu_func3, alu_func7, alu_rs1, alu_rs2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(posedge clk); @(negedge clk);
    dbg_we = 1'b0;
    if (a != 5'd0) ref_rf[a] = d;
  endtask

  // Issues one instruction starting at a negedge in IDLE; ends at a negedge back in IDLE.
  task automatic issue(input logic [31:0] ins, input bit acc_dbg);
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    logic [31:0] a, b, exp;
    rs1 = ins[19:15]; rs2 = ins[24:20]; rd = ins[11:7];
    f3 = ins[14:12]; f7 = ins[31:25];
    legal = (ins[6:0] == 7'h33) &&
            ((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
    check("idle_ready", instr_ready, 1);
    instr_valid = 1'b1; instr = ins;
    if (acc_dbg) begin
      dbg_we = 1'b1; dbg_addr = 5'($urandom); dbg_wdata = $urandom;
      if (dbg_addr != 5'd0) ref_rf[dbg_addr] = dbg_wdata;
    end
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    dbg_we = 1'b1; dbg_addr = 5'($urandom); dbg_wdata = $urandom;
    a = ref_rf[rs1]; b = ref_rf[rs2];
    check("dec_ready", instr_ready, 0);
    check("dec_illegal", illegal, {31'd0, !legal});
    check("dec_req", alu_req, 0);
    @(negedge clk);
    dbg_we = 1'b0; dbg_addr = rd;
    if (!legal) begin
`ifdef ALU_R_ISSUE_PERF_EN
      exp_ill++;
`endif
      check("ill_ready", instr_ready, 1);
      check("ill_pulse", illegal, 0);
      check("ill_req", alu_req, 0);
      check("ill_wb", wb_valid, 0);
      return;
    end
    for (int k = 0; k < LAT; k++) begin
      check("ex_req", alu_req, 1);
      check("ex_f3", alu_func3, f3);
      check("ex_f7", alu_func7, f7);
      check("ex_rs1", alu_rs1, a);
      check("ex_rs2", alu_rs2, b);
      @(negedge clk);
    end
    exp = alu_fn(f3, f7, a, b);
    check("wb_valid", wb_valid, 1);
    check("wb_rd", wb_rd, rd);
    check("wb_data", wb_data, exp);
    check("wb_req", alu_req, 0);
    check("wb_dbg_old", dbg_rdata, ref_rf[rd]);
    if (rd != 5'd0) ref_rf[rd] = exp;
`ifdef ALU_R_ISSUE_PERF_EN
    exp_ret++;
`endif
    @(negedge clk);
    check("post_wb", wb_valid, 0);
    check("post_ready", instr_ready, 1);
    check("post_dbg_new", dbg_rdata, ref_rf[rd]);
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 check(tag, dbg_rdata, ref_rf[i]);
    end
  endtask

  initial begin
    int unsigned accepts[$];
    int          cyc;
    logic [31:0] ins;
    logic [6:0]  op, f7;
    int unsigned r;

    rst_n = 1'b0; instr_valid = 1'b0; instr_valid3 = 1'b0; instr = '0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", instr_ready, 1);
    check("rst_wb", wb_valid, 0);
    check("rst_illegal", illegal, 0);
    check("rst_req", alu_req, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_regs("rst_reg");

    // Directed: ADD, SUB, two illegal forms, write to x0.
    dbg_write(5'd1, 32'd5);
    dbg_write(5'd2, 32'd3);
    issue(32'h002081B3, 1'b0);
    dbg_addr = 5'd3; #1 check("add_x3", dbg_rdata, 32'd8);
    issue(32'h40110233, 1'b0);
    dbg_addr = 5'd4; #1 check("sub_x4", dbg_rdata, 32'hFFFFFFFE);
    issue(32'h00108093, 1'b0);
    issue(32'h4020F1B3, 1'b0);
    issue(32'h00208033, 1'b0);
    dbg_addr = 5'd0; #1 check("x0_zero", dbg_rdata, 32'd0);

    // Randomized instructions against the register-file model.
    for (int i = 1; i < 32; i++) dbg_write(5'(i), $urandom);
    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(0, 9);
      op = 7'h33;
      f7 = 7'h00;
      if (r == 6 || r == 7) f7 = 7'h20;
      else if (r == 8)      f7 = 7'($urandom);
      else if (r == 9)      op = 7'($urandom);
      ins = {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), op};
      if ($urandom_range(0, 3) == 0) dbg_write(5'($urandom), $urandom);
      issue(ins, $urandom_range(0, 3) == 0);
    end
    check_all_regs("rand_reg");
`ifdef ALU_R_ISSUE_PERF_EN
    check("perf_ret", perf_retired, exp_ret);
    check("perf_ill", perf_illegal, exp_ill);
`endif

    // Reset asserted in the middle of EXEC.
    instr_valid = 1'b1; instr = 32'h002082B3;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("rx_req", alu_req, 1);
    #2 rst_n = 1'b0;
    #1 check("rx_abort_req", alu_req, 0);
    check("rx_abort_ready", instr_ready, 1);
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rx_no_wb", wb_valid, 0);
      check("rx_no_ill", illegal, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rx_ready", instr_ready, 1);
    check("rx_wb", wb_valid, 0);
    check_all_regs("rx_reg");
`ifdef ALU_R_ISSUE_PERF_EN
    check("rx_perf_ret", perf_retired, 0);
    check("rx_perf_ill", perf_illegal, 0);
`endif

    // Back-to-back issue on the ALU_LAT=3 instance with instr_valid held high.
    instr = 32'h00208033;
    instr_valid3 = 1'b1;
    for (cyc = 0; cyc < 45; cyc++) begin
      if (wb_valid3) begin
        if (accepts.size() == 0) check("tput_wb_early", 1, 0);
        else check("tput_lat", cyc - accepts[accepts.size()-1], 32'(2 + LAT3));
        check("tput_wb_rd", wb_rd3, 0);
      end
      if (instr_ready3) accepts.push_back(cyc);
      @(negedge clk);
    end
    instr_valid3 = 1'b0;
    check("tput_count", 32'(accepts.size() >= 6), 1);
    for (int i = 1; i < accepts.size(); i++)
      check("tput_gap", accepts[i] - accepts[i-1], 32'(3 + LAT3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_r_issue.md
Name: alu_r_issue

Overview:
- Issue/writeback front end for the R-type ALU. It accepts RV32I R-type instruction words over a valid/ready handshake and decodes them.
- It reads operands from an internal 32x32 register file and drives func3/func7/rs1/rs2 to the ALU.
- It captures the ALU result and writes it back to rd.
- It sits between instruction fetch/test driver and the combinational ALU.

Parameters:
- ALU_LAT, 1, EXEC cycles to hold operands before sampling alu_result; legal range 1..8.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- instr_valid  in  1  instruction word valid
- instr_ready  out  1  block can accept an instruction
- instr  in  32  RV32 instruction word
- alu_req  out  1  operands valid at ALU
- alu_func3  out  3  instr[14:12]
- alu_func7  out  7  instr[31:25]
- alu_rs1  out  32  value of register rs1
- alu_rs2  out  32  value of register rs2
- alu_result  in  32  ALU result
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  5  destination register index
- wb_data  out  32  written value
- illegal  out  1  one-cycle pulse: instruction rejected
- dbg_we  in  1  debug register write enable
- dbg_addr  in  5  debug read/write index
- dbg_wdata  in  32  debug write data
- dbg_rdata  out  32  combinational read of regfile[dbg_addr]

Behaviour:
- Reset: clk is the single clock. rst_n is asynchronous, active-low. All outputs 0 except instr_ready=1. All 32 registers cleared. FSM goes to IDLE.
- FSM states: IDLE, DECODE, EXEC, WB.
- IDLE: instr_ready=1. Handshake instr_valid&&instr_ready at edge T latches instr. Next state DECODE.
- DECODE (T+1):
  - Check legality. opcode must be 0110011.
  - func7=0000000 is legal for any func3.
  - func7=0100000 is legal only for func3=000 (SUB) or 101 (SRA).
  - Legal: latch regfile[rs1] and regfile[rs2] into operand registers. Next state EXEC.
  - Illegal: illegal=1 this cycle. No ALU request, no writeback. Next state IDLE.
- EXEC: lasts ALU_LAT cycles (counter). alu_req=1; alu_func3, alu_func7, alu_rs1, alu_rs2 are registered and stable throughout. alu_result is sampled at the end of the final EXEC cycle. Next state WB.
- WB: wb_valid=1, wb_rd=rd, wb_data=sampled result. Regfile is written at the end of the cycle unless rd=0. Next state IDLE.
- Latency: accept→wb_valid = 2+ALU_LAT cycles. Throughput: one instruction per 3+ALU_LAT cycles. instr_ready=0 outside IDLE.
- ALU outputs hold their last values when alu_req=0; wb_* hold their last values. Bench checks ALU and wb_* outputs only while alu_req/wb_valid is high.
- x0 reads 0 on every read path. Writes to x0 from WB or debug are discarded. wb_valid still pulses with wb_rd=0.
- Debug write occurs only when dbg_we=1 and state==IDLE; ignored otherwise. A debug write in the accept cycle is visible to that instruction's DECODE read.
- dbg_rdata in the WB cycle for the same index returns the old value; the new value is visible from the next cycle.
- No read-during-write hazard exists: WB completes before the next DECODE.
- rst_n low mid-operation: immediate abort, no wb_valid/illegal pulse, regfile cleared.

Optional Feature:
- Macro: ALU_R_ISSUE_PERF_EN.
- Defined: adds outputs perf_retired[31:0] and perf_illegal[31:0], reset to 0.
  - perf_retired +1 on each wb_valid; perf_illegal +1 on each illegal pulse.
  - Both wrap 0xFFFFFFFF→0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package alu_r_pkg holds:
  - OPC_OP=7'b0110011
  - F7_BASE=7'b0000000
  - F7_ALT=7'b0100000
  - func3 constants ADD_SUB=000, SLL=001, SLT=010, SLTU=011, XOR=100, SRL_SRA=101, OR=110, AND=111
  - FSM state encoding
- Sub-module alu_r_regfile: 32x32, two async read ports plus dbg read port, one write port, async clear, x0 hardwired zero.

Test Plan:
- Reset → instr_ready=1, wb_valid=0, illegal=0, dbg_rdata=0 for all 32 indices.
- ADD (ALU_LAT=1, golden ALU model):
  - Stimulus: dbg write x1=5, x2=3; issue 0x002081B3 (ADD x3,x1,x2).
  - At T+2: alu_req=1, func3=0, func7=0, rs1=5, rs2=3.
  - At T+3: wb_valid=1, wb_rd=3, wb_data=8.
  - Afterwards dbg read x3=8.
- SUB: issue 0x40110233 (SUB x4,x2,x1) → func7=0x20, wb_data=0xFFFFFFFE into x4.
- Illegal:
  - Issue 0x00108093 (ADDI) → illegal=1 at T+1, no alu_req, no wb_valid, instr_ready=1 at T+2.
  - Repeat with func7=0100000, func3=111 → same response.
- rd=x0 and throughput:
  - Issue 0x00208033 (ADD x0,x1,x2) → wb_valid, wb_rd=0, wb_data=8; dbg read x0=0.
  - Hold instr_valid with ALU_LAT=3 → accepts exactly every 6 cycles.
- Reset during EXEC:
  - Stimulus: rst_n low during EXEC.
  - No wb_valid; regs cleared; instr_ready=1 after release.
  - With ALU_R_ISSUE_PERF_EN, counters=0.
